// File: rtl/sakebi_fcs_pkg.sv
// Shared types, constants and bit-reflection helpers for the transmit FCS inserter.
package sakebi_fcs_pkg;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    FLUSH  = 2'd1,
    APPEND = 2'd2
  } state_t;

  localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;
  localparam int          FCS_BYTES   = 4;
  localparam int          FLUSH_BYTES = 4;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

endpackage

// File: rtl/sakebi_fcs_inserter_crc.sv
// Combinational CRC remainder: o_crc = i_data mod (x^OUTPUT_WIDTH + CRC), MSB first.
// No state; one feed step of the augmented (non-direct) CRC algorithm.
module sakebi_crc32_calculator #(
  parameter int                      INPUT_WIDTH  = 40,
  parameter int                      OUTPUT_WIDTH = 32,
  parameter logic [OUTPUT_WIDTH-1:0] CRC          = 32'h04C11DB7
) (
  input  logic [INPUT_WIDTH-1:0]  i_data,
  output logic [OUTPUT_WIDTH-1:0] o_crc
);

  logic [INPUT_WIDTH-1:0] rem;

  always_comb begin
    rem = i_data;
    // Long division: cancel each set bit above the remainder window with the full generator.
    for (int i = INPUT_WIDTH - 1; i >= OUTPUT_WIDTH; i--) begin
      if (rem[i]) rem[i -: OUTPUT_WIDTH+1] = rem[i -: OUTPUT_WIDTH+1] ^ {1'b1, CRC};
    end
    o_crc = rem[OUTPUT_WIDTH-1:0];
  end

endmodule

// File: rtl/sakebi_fcs_inserter.sv
// Ethernet TX FCS inserter: zero-latency payload pass-through, 4-cycle CRC flush, then FCS LSB byte first.
// First FCS byte is valid 5 cycles after the last payload transfer; FCS bytes hold while i_ready is low.
module sakebi_fcs_inserter
  import sakebi_fcs_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] CRC        = CRC32_POLY,
  parameter int                   MIN_LEN    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_len_err
);

  localparam logic [2:0] CNT_SAT    = 3'd4;
  localparam logic [2:0] MIN_LEN_C  = 3'(MIN_LEN);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_BYTES - 1);
  localparam logic [1:0] FCS_LAST   = 2'(FCS_BYTES - 1);

  state_t               state, state_nxt;
  logic [CRC_WIDTH-1:0] crc_reg, next_crc;
  logic [2:0]           byte_cnt, byte_cnt_nxt;
  logic [1:0]           flush_cnt, fcs_idx;
  logic                 len_err;
  logic [7:0]           src_byte, feed_byte;
  logic                 xfer_in, xfer_out, feed;
  logic [31:0]          fcs;
  logic                 ready_c, valid_c, last_c;

  // The first four fed bytes are inverted, which is the 0xFFFFFFFF preset of the
  // augmented algorithm; for short frames that inversion spills onto flush bytes.
  always_comb begin
    src_byte     = (state == DATA) ? i_data : 8'h00;
    feed_byte    = bitrev8(src_byte) ^ ((byte_cnt < CNT_SAT) ? 8'hFF : 8'h00);
    xfer_in      = (state == DATA) && i_valid && i_ready;
    xfer_out     = (state == APPEND) && i_ready;
    feed         = xfer_in || (state == FLUSH);
    byte_cnt_nxt = (feed && (byte_cnt < CNT_SAT)) ? byte_cnt + 3'd1 : byte_cnt;
    fcs          = bitrev32(~crc_reg);
  end

  sakebi_crc32_calculator #(
    .INPUT_WIDTH (CRC_WIDTH + 8),
    .OUTPUT_WIDTH(CRC_WIDTH),
    .CRC         (CRC)
  ) u_crc (
    .i_data({crc_reg, feed_byte}),
    .o_crc (next_crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= DATA;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    last_c    = 1'b0;
    o_data    = '0;
    case (state)
      DATA: begin
        ready_c = i_ready;
        valid_c = i_valid;
        o_data  = i_data;
        if (xfer_in && i_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nxt = APPEND;
      end
      APPEND: begin
        valid_c = 1'b1;
        o_data  = fcs[{fcs_idx, 3'b000} +: 8];
        last_c  = (fcs_idx == FCS_LAST);
        if (xfer_out && last_c) state_nxt = DATA;
      end
      default: state_nxt = DATA;
    endcase
  end

  // Handshake outputs are forced low while reset is held, independent of the inputs.
  assign o_ready   = ready_c & i_rst_n;
  assign o_valid   = valid_c & i_rst_n;
  assign o_last    = last_c & i_rst_n;
  assign o_len_err = len_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_reg   <= '0;
      byte_cnt  <= '0;
      flush_cnt <= '0;
      fcs_idx   <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err   <= xfer_in && i_last && (byte_cnt_nxt < MIN_LEN_C);
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (xfer_out && (fcs_idx == FCS_LAST)) begin
        crc_reg  <= '0;
        byte_cnt <= '0;
        fcs_idx  <= '0;
      end else begin
        if (feed)     crc_reg <= next_crc;
        byte_cnt <= byte_cnt_nxt;
        if (xfer_out) fcs_idx <= fcs_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sakebi_fcs_inserter.sv
// Directed bench for sakebi_fcs_inserter: known CRC-32 vectors, backpressure, back-to-back, reset and short frames.
module tb_sakebi_fcs_inserter;

  logic       i_clk, i_rst_n, i_valid, i_last, i_ready;
  logic       o_ready, o_valid, o_last, o_len_err;
  logic [7:0] i_data, o_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] out_q[$];
  logic       last_q[$];
  int         cyc_q[$], lx_q[$], fcs_cyc_q[$], lenerr_q[$];
  int         stab_viol = 0, rdy_viol = 0;
  logic       tail = 0, fcs_seen = 0, prev_stall = 0;
  logic [7:0] prev_data = 0;

  logic [7:0] pay[16];
  int         pay_len = 0;
  logic [7:0] exp_dat[32];
  logic       exp_lst[32];
  int         exp_n = 0;
  int         rdy_mode = 0;

  sakebi_fcs_inserter dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .i_ready  (i_ready),
    .o_len_err(o_len_err)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  initial forever @(posedge i_clk) cyc++;

  // Downstream ready: constant 1, or a repeating 1-0-0-1 pattern.
  initial begin
    logic [3:0] pat;
    int phase;
    pat = 4'b1001;
    phase = 0;
    i_ready = 1;
    forever begin
      @(posedge i_clk);
      #1;
      if (rdy_mode == 0) i_ready = 1;
      else begin
        i_ready = pat[phase % 4];
        phase++;
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      tail = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall && (!o_valid || o_data != prev_data)) stab_viol++;
      if (tail && o_ready) rdy_viol++;
      if (tail && o_valid && !fcs_seen) begin
        fcs_cyc_q.push_back(cyc);
        fcs_seen = 1;
      end
      if (o_len_err) lenerr_q.push_back(cyc);
      if (o_valid && i_ready) begin
        out_q.push_back(o_data);
        last_q.push_back(o_last);
        cyc_q.push_back(cyc);
        if (o_last) tail = 0;
      end
      if (i_valid && i_last && o_ready && !tail) begin
        tail = 1;
        fcs_seen = 0;
        lx_q.push_back(cyc);
      end
      prev_stall = o_valid && !i_ready;
      prev_data = o_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic load(input string s);
    pay_len = s.len();
    for (int i = 0; i < pay_len; i++) pay[i] = s[i];
  endtask

  task automatic exp_add(input logic [7:0] b, input logic l);
    exp_dat[exp_n] = b;
    exp_lst[exp_n] = l;
    exp_n++;
  endtask

  task automatic exp_payload();
    for (int i = 0; i < pay_len; i++) exp_add(pay[i], 1'b0);
  endtask

  task automatic exp_fcs(input logic [31:0] f);
    for (int k = 0; k < 4; k++) exp_add(f[8*k +: 8], k == 3);
  endtask

  function automatic logic [31:0] crc32_ref();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < pay_len; i++) begin
      c = c ^ {24'h0, pay[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send_bytes(input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int g;
      i_valid = 1;
      i_data = pay[k];
      i_last = with_last && (k == n - 1);
      acc = 0;
      g = 0;
      while (!acc && g < 200) begin
        @(negedge i_clk);
        acc = o_ready;
        g++;
        @(posedge i_clk);
        #1;
      end
      if (!acc) check("xfer_timeout", 0, 1);
    end
    i_valid = 0;
    i_last = 0;
  endtask

  task automatic wait_outs(input int n, input string tag);
    int g;
    g = 0;
    while (out_q.size() < n && g < 1000) begin
      @(posedge i_clk);
      g++;
    end
    check(tag, out_q.size(), n);
    #1;
  endtask

  task automatic check_stream(input int base, input string tag);
    check({tag, "_len"}, out_q.size() - base, exp_n);
    for (int k = 0; k < exp_n; k++) begin
      if (base + k < out_q.size()) begin
        check($sformatf("%s_d%0d", tag, k), out_q[base+k], exp_dat[k]);
        check($sformatf("%s_l%0d", tag, k), last_q[base+k], exp_lst[k]);
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] fcs, input int exp_le);
    int base, lxb, fb, leb;
    base = out_q.size();
    lxb = lx_q.size();
    fb = fcs_cyc_q.size();
    leb = lenerr_q.size();
    exp_n = 0;
    exp_payload();
    exp_fcs(fcs);
    send_bytes(pay_len, 1);
    wait_outs(base + pay_len + 4, {tag, "_done"});
    repeat (2) @(posedge i_clk);
    #1;
    check_stream(base, tag);
    if (fcs_cyc_q.size() > fb && lx_q.size() > lxb)
      check({tag, "_lat"}, fcs_cyc_q[fb] - lx_q[lxb], 5);
    else check({tag, "_lat_missing"}, 0, 1);
    check({tag, "_lenerr_cnt"}, lenerr_q.size() - leb, exp_le);
    if (exp_le == 1 && lenerr_q.size() > leb && lx_q.size() > lxb)
      check({tag, "_lenerr_cyc"}, lenerr_q[leb] - lx_q[lxb], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sv, rv;
    i_rst_n = 0;
    i_valid = 1;
    i_last = 1;
    i_data = 8'hA5;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_last", o_last, 0);
    check("rst_lenerr", o_len_err, 0);
    @(posedge i_clk);
    #1;
    i_valid = 0;
    i_rst_n = 1;
    repeat (3) @(posedge i_clk);
    #1;
    i_last = 0;

    // 1: "123456789" -> CBF43926, 17-cycle frame
    load("123456789");
    base = out_q.size();
    run_frame("t1", 32'hCBF4_3926, 0);
    if (cyc_q.size() >= base + 13) check("t1_span", cyc_q[base+12] - cyc_q[base] + 1, 17);

    // 2: "abcd", exactly the minimum length
    load("abcd");
    run_frame("t2", 32'hED82_CD11, 0);

    // 3: test 1 under 1-0-0-1 backpressure
    sv = stab_viol;
    rv = rdy_viol;
    rdy_mode = 1;
    load("123456789");
    run_frame("t3", 32'hCBF4_3926, 0);
    rdy_mode = 0;
    check("t3_stable", stab_viol - sv, 0);
    check("t3_rdy_tail", rdy_viol - rv, 0);

    // 4: back-to-back "abcd" then "123456789"
    base = out_q.size();
    exp_n = 0;
    load("abcd");
    exp_payload();
    exp_fcs(32'hED82_CD11);
    send_bytes(4, 1);
    load("123456789");
    exp_payload();
    exp_fcs(32'hCBF4_3926);
    send_bytes(9, 1);
    wait_outs(base + 21, "t4_done");
    check_stream(base, "t4");
    if (cyc_q.size() >= base + 9) check("t4_b2b", cyc_q[base+8] - cyc_q[base+7], 1);

    // 5a: reset after 5 of 9 payload bytes
    load("123456789");
    send_bytes(5, 0);
    i_valid = 1;
    i_data = pay[5];
    #2;
    i_rst_n = 0;
    #1;
    check("t5a_valid", o_valid, 0);
    check("t5a_ready", o_ready, 0);
    check("t5a_last", o_last, 0);
    check("t5a_lenerr", o_len_err, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_valid = 0;
    i_rst_n = 1;
    load("abcd");
    run_frame("t5a", 32'hED82_CD11, 0);

    // 5b: reset while the third FCS byte is on the bus
    load("abcd");
    base = out_q.size();
    send_bytes(4, 1);
    wait_outs(base + 6, "t5b_reach");
    check("t5b_idx2_valid", o_valid, 1);
    check("t5b_idx2_data", o_data, 8'h82);
    i_rst_n = 0;
    #1;
    check("t5b_valid", o_valid, 0);
    check("t5b_last", o_last, 0);
    check("t5b_ready", o_ready, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
    repeat (10) @(posedge i_clk);
    #1;
    check("t5b_abandoned", out_q.size() - base, 6);
    run_frame("t5b", 32'hED82_CD11, 0);

    // 6: 2-byte frame flags a length error, FCS from the reference model
    load("ab");
    run_frame("t6", crc32_ref(), 1);

    check("stable_total", stab_viol, 0);
    check("rdy_tail_total", rdy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
